maxfifo_window_buffer: RTL

Line-buffered window builder that turns a raster-order pixel stream from the conv/ReLU stage into non-overlapping KERNEL_SIZE×KERNEL_SIZE windows for the max-pool path. It sits directly upstream of the maxfifo→maxpool pipeline register. It drives that register's window_maxfifo and maxpool_en_maxfifo inputs, one window per stride-KERNEL_SIZE position.

---
 rtl/maxfifo_window_buffer_pkg.sv | 16 +
 rtl/maxfifo_window_buffer_if.sv | 29 ++
 rtl/maxfifo_window_buffer_line_buffer.sv | 28 ++
 rtl/maxfifo_window_buffer.sv | 107 ++++++++++
 4 files changed

// File: rtl/maxfifo_window_buffer_pkg.sv
// Shared definitions for the max-pool window path.
// Holds the default kernel/pixel sizes, the pixel typedef and a width helper
// used to size the column/row counters inside the modules.
package maxpool_pkg;

    localparam int KERNEL_SIZE_DEF = 2;
    localparam int DATA_WIDTH_DEF  = 16;

    typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxfifo_window_buffer_if.sv
// Pixel-in / window-out bundle between the conv/ReLU stream and the
// maxfifo->maxpool register.
//   pixel_valid, pixel_in        : raster-order pixel stream (producer drives)
//   maxpool_en_maxfifo           : one-cycle strobe, new window available
//   window_maxfifo[r][c]         : r = row (0 = top), c = column (0 = left)
//   frame_done                   : one-cycle strobe after last pixel of frame
// master = stream producer / window consumer, slave = window builder.
interface maxfifo_window_buffer_if
    import maxpool_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
);
    logic                                                    pixel_valid;
    logic [DATA_WIDTH-1:0]                                   pixel_in;
    logic                                                    maxpool_en_maxfifo;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_maxfifo;
    logic                                                    frame_done;

    modport master (
        output pixel_valid, pixel_in,
        input  maxpool_en_maxfifo, window_maxfifo, frame_done
    );

    modport slave (
        input  pixel_valid, pixel_in,
        output maxpool_en_maxfifo, window_maxfifo, frame_done
    );
endinterface

// File: rtl/maxfifo_window_buffer_line_buffer.sv
// One-row delay line for the window builder.
// Read is combinational from addr, write lands on the clock edge, so a read
// and write to the same address in one cycle returns the old (previous row)
// value. Contents are not reset.
//   clk  : clock
//   addr : column index
//   we   : write enable (pixel accepted)
//   din  : value stored for the next row
//   dout : value stored by the previous row at addr
module maxfifo_line_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end
endmodule

// File: rtl/maxfifo_window_buffer.sv
// Builds non-overlapping KERNEL_SIZE x KERNEL_SIZE windows from a raster
// pixel stream and hands them to the maxfifo->maxpool register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of maxfifo_window_buffer_if (pixels in, windows out)
// Parameters must match those of the connected interface instance.
module maxfifo_window_buffer
    import maxpool_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    maxfifo_window_buffer_if.slave   bus
);
    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);
    localparam int KW    = cnt_w(KERNEL_SIZE);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    // Position inside the current kernel cell; avoids a modulo on col/row.
    logic [KW-1:0]    kcol, krow;

    logic [DATA_WIDTH-1:0] v [KERNEL_SIZE];
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] sr;

    logic col_last, row_last, kcol_last, krow_last, emit;

    assign col_last  = (col  == COL_W'(IMG_WIDTH - 1));
    assign row_last  = (row  == ROW_W'(IMG_HEIGHT - 1));
    assign kcol_last = (kcol == KW'(KERNEL_SIZE - 1));
    assign krow_last = (krow == KW'(KERNEL_SIZE - 1));
    // Emitting rows always sit K-1 rows into a kernel cell of this frame,
    // so the line buffers they read were written in this frame.
    assign emit      = bus.pixel_valid && kcol_last && krow_last;

    assign v[KERNEL_SIZE-1] = bus.pixel_in;

    // Chain of row delays: lb[i] feeds v[i] and stores v[i+1].
    for (genvar i = 0; i < KERNEL_SIZE - 1; i++) begin : g_lb
        maxfifo_line_buffer #(
            .DEPTH      (IMG_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_W     (COL_W)
        ) u_lb (
            .clk  (clk),
            .addr (col),
            .we   (bus.pixel_valid),
            .din  (v[i+1]),
            .dout (v[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            kcol <= '0;
            krow <= '0;
        end else if (bus.pixel_valid) begin
            if (col_last) begin
                col  <= '0;
                kcol <= '0;      // drops any partial trailing column cell
                if (row_last) begin
                    row  <= '0;
                    krow <= '0;  // drops any partial trailing row cell
                end else begin
                    row  <= row + 1'b1;
                    krow <= krow_last ? '0 : krow + 1'b1;
                end
            end else begin
                col  <= col + 1'b1;
                kcol <= kcol_last ? '0 : kcol + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr                     <= '0;
            bus.window_maxfifo     <= '0;
            bus.maxpool_en_maxfifo <= 1'b0;
            bus.frame_done         <= 1'b0;
        end else begin
            bus.maxpool_en_maxfifo <= emit;
            bus.frame_done         <= bus.pixel_valid && col_last && row_last;
            if (bus.pixel_valid) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++)
                        sr[r][c] <= sr[r][c+1];
                    sr[r][KERNEL_SIZE-1] <= v[r];
                end
            end
            // Window is the shift register as it will be after this pixel.
            if (emit) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++)
                        bus.window_maxfifo[r][c] <= sr[r][c+1];
                    bus.window_maxfifo[r][KERNEL_SIZE-1] <= v[r];
                end
            end
        end
    end
endmodule
